bcd_gate_counter: RTL and testbench

//  Parametrised N-digit BCD event counter for the frequency meter.
//  - Counts cin strobes only while the measurement window input (gate) is high.
//  - At the end of each window it latches the count into data and pulses data_valid.
//  - Flags overflow and supports either saturate or wrap mode.
//  - Sits between the gate-time generator and the display/BCD decode path.

---
 rtl/bcd_gate_counter.sv | 115 +++++++++++
 tb/tb_bcd_gate_counter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/bcd_gate_counter.sv
// bcd_gate_counter: N-digit BCD event counter gated by a measurement window.
// Counts cin strobes while gate is high, latches the result into data at the
// end of the window with a one-cycle data_valid pulse, and flags overflow
// (saturating at all-9s or wrapping to all-0s depending on SATURATE).
module bcd_gate_counter #(
  parameter int unsigned DIGITS   = 6,
  parameter bit          SATURATE = 1'b1
) (
  input  logic                  clk_2,
  input  logic                  Rst_n,
  input  logic                  gate,
  input  logic                  cin,
  output logic [4*DIGITS-1:0]   data,
  output logic                  data_valid,
  output logic                  ovf,
  output logic                  cout,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    LATCH = 2'd2,
    CLEAR = 2'd3
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [4*DIGITS-1:0] count;
  logic [4*DIGITS-1:0] count_inc;
  logic                carry;
  logic                inc;
  logic                ovf_int;

  // State register
  always_ff @(posedge clk_2) begin
    if (!Rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state decode and increment enable
  always_comb begin
    state_next = state;
    inc        = 1'b0;
    unique case (state)
      IDLE:  if (gate) state_next = COUNT;
      COUNT: begin
        if (!gate) state_next = LATCH;
        else       inc        = cin;
      end
      LATCH: state_next = CLEAR;
      CLEAR: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Ripple BCD increment; carry out of the top digit means count is all-9s
  always_comb begin
    count_inc = count;
    carry     = 1'b1;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (carry) begin
        if (count[4*d +: 4] == 4'd9) begin
          count_inc[4*d +: 4] = 4'd0;
        end else begin
          count_inc[4*d +: 4] = count[4*d +: 4] + 4'd1;
          carry               = 1'b0;
        end
      end
    end
  end

  // Window counter, sticky in-window overflow and carry-out pulse
  always_ff @(posedge clk_2) begin
    if (!Rst_n) begin
      count   <= '0;
      ovf_int <= 1'b0;
      cout    <= 1'b0;
    end else begin
      cout <= 1'b0;
      if (inc) begin
        if (carry) begin
          ovf_int <= 1'b1;
          cout    <= 1'b1;
          if (!SATURATE) count <= '0;
        end else begin
          count <= count_inc;
        end
      end
      if (state == CLEAR) begin
        count   <= '0;
        ovf_int <= 1'b0;
      end
    end
  end

  // Result latch: data/ovf hold between windows, data_valid pulses once
  always_ff @(posedge clk_2) begin
    if (!Rst_n) begin
      data       <= '0;
      ovf        <= 1'b0;
      data_valid <= 1'b0;
    end else begin
      data_valid <= (state == LATCH);
      if (state == LATCH) begin
        data <= count;
        ovf  <= ovf_int;
      end
    end
  end

  // Busy whenever a window is in progress or being closed out
  always_comb busy = (state != IDLE);

endmodule

// File: tb/tb_bcd_gate_counter.sv
// tb_bcd_gate_counter: drives three counter configurations (6-digit saturate,
// 2-digit saturate, 2-digit wrap) from one gate/cin sequence and compares
// every cycle against expectations derived from the window description.
module tb_bcd_gate_counter;

  logic        clk_2 = 1'b0;
  logic        Rst_n = 1'b0;
  logic        gate  = 1'b0;
  logic        cin   = 1'b0;

  logic [23:0] data_a;
  logic [7:0]  data_b, data_c;
  logic        dv_a, dv_b, dv_c;
  logic        ovf_a, ovf_b, ovf_c;
  logic        cout_a, cout_b, cout_c;
  logic        busy_a, busy_b, busy_c;

  int checks = 0;
  int passed = 0;

  bit gq[$];
  bit cq[$];

  always #5 clk_2 = ~clk_2;

  bcd_gate_counter #(.DIGITS(6), .SATURATE(1'b1)) u_a (
    .clk_2(clk_2), .Rst_n(Rst_n), .gate(gate), .cin(cin),
    .data(data_a), .data_valid(dv_a), .ovf(ovf_a), .cout(cout_a), .busy(busy_a));

  bcd_gate_counter #(.DIGITS(2), .SATURATE(1'b1)) u_b (
    .clk_2(clk_2), .Rst_n(Rst_n), .gate(gate), .cin(cin),
    .data(data_b), .data_valid(dv_b), .ovf(ovf_b), .cout(cout_b), .busy(busy_b));

  bcd_gate_counter #(.DIGITS(2), .SATURATE(1'b0)) u_c (
    .clk_2(clk_2), .Rst_n(Rst_n), .gate(gate), .cin(cin),
    .data(data_c), .data_valid(dv_c), .ovf(ovf_c), .cout(cout_c), .busy(busy_c));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic int pow10(input int d);
    int p = 1;
    repeat (d) p *= 10;
    return p;
  endfunction

  // Value held in a d-digit counter after n increments
  function automatic int exp_count(input int n, input int d, input bit sat);
    int lim = pow10(d);
    if (n < lim) return n;
    return sat ? lim - 1 : n % lim;
  endfunction

  // Number of increments attempted while already at all-9s
  function automatic int exp_couts(input int n, input int d, input bit sat);
    int lim = pow10(d);
    if (sat) return (n >= lim) ? n - (lim - 1) : 0;
    return n / lim;
  endfunction

  function automatic logic [31:0] to_bcd(input int v);
    logic [31:0] r = '0;
    for (int k = 0; k < 6; k++) begin
      r[4*k +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Append a window: hi gate-high cycles then gap gate-low cycles.
  // mode 0: cin always high, 1: cin low, 2: random, 3: every third counted cycle
  task automatic add_win(input int hi, input int mode, input int gap);
    for (int j = 0; j < hi; j++) begin
      gq.push_back(1'b1);
      case (mode)
        0:       cq.push_back(1'b1);
        1:       cq.push_back(1'b0);
        2:       cq.push_back(1'($urandom));
        default: cq.push_back(j >= 1 && (j - 1) % 3 == 0);
      endcase
    end
    for (int k = 0; k < gap; k++) begin
      gq.push_back(1'b0);
      cq.push_back((k == 0 && mode == 0) ? 1'b1 : 1'($urandom));
    end
  endtask

  task automatic add_low(input int n);
    for (int k = 0; k < n; k++) begin
      gq.push_back(1'b0);
      cq.push_back(1'($urandom));
    end
  endtask

  // Reset, then play the queued sequence checking every cycle
  task automatic run_segment(input string name);
    int L, ready, s, e, n;
    int exp_n[];
    bit exp_dv[];
    bit exp_busy[];
    int seen_b, seen_c, want_b, want_c;
    L = gq.size();
    exp_n    = new[L];
    exp_dv   = new[L];
    exp_busy = new[L];
    foreach (exp_n[j]) begin
      exp_n[j] = 0; exp_dv[j] = 1'b0; exp_busy[j] = 1'b0;
    end

    // A window opens at the first gate-high cycle the idle counter can see,
    // counts cin on the following gate-high cycles, and closes at gate low;
    // the result appears one cycle after the closing cycle and a new window
    // can only be seen three cycles after it.
    ready = 0;
    forever begin
      s = -1;
      for (int j = ready; j < L; j++) if (gq[j]) begin s = j; break; end
      if (s < 0) break;
      e = -1; n = 0;
      for (int j = s + 1; j < L; j++) begin
        if (!gq[j]) begin e = j; break; end
        n += int'(cq[j]);
      end
      if (e < 0) begin
        for (int j = s; j < L; j++) exp_busy[j] = 1'b1;
        break;
      end
      for (int j = s; j <= e + 1 && j < L; j++) exp_busy[j] = 1'b1;
      if (e + 1 < L) begin
        exp_dv[e + 1] = 1'b1;
        for (int j = e + 1; j < L; j++) exp_n[j] = n;
      end
      ready = e + 3;
    end

    Rst_n = 1'b0; gate = 1'b0; cin = 1'b0;
    repeat (2) @(posedge clk_2);
    #1;
    chk({name, " reset data_a"}, 32'(data_a), 32'd0);
    chk({name, " reset data_b"}, 32'(data_b), 32'd0);
    chk({name, " reset data_c"}, 32'(data_c), 32'd0);
    chk({name, " reset dv"},   {29'd0, dv_a, dv_b, dv_c},       32'd0);
    chk({name, " reset ovf"},  {29'd0, ovf_a, ovf_b, ovf_c},    32'd0);
    chk({name, " reset cout"}, {29'd0, cout_a, cout_b, cout_c}, 32'd0);
    chk({name, " reset busy"}, {29'd0, busy_a, busy_b, busy_c}, 32'd0);
    Rst_n = 1'b1;

    seen_b = 0; seen_c = 0; want_b = 0; want_c = 0;
    for (int i = 0; i < L; i++) begin
      gate = gq[i];
      cin  = cq[i];
      @(posedge clk_2);
      #1;
      chk($sformatf("%s cout_a@%0d", name, i), 32'(cout_a), 32'd0);
      if (cout_b === 1'b1) seen_b++;
      if (cout_c === 1'b1) seen_c++;
      chk($sformatf("%s dv@%0d", name, i), {29'd0, dv_a, dv_b, dv_c},
          exp_dv[i] ? 32'd7 : 32'd0);
      chk($sformatf("%s busy@%0d", name, i), {29'd0, busy_a, busy_b, busy_c},
          exp_busy[i] ? 32'd7 : 32'd0);
      chk($sformatf("%s data_a@%0d", name, i), 32'(data_a),
          to_bcd(exp_count(exp_n[i], 6, 1'b1)));
      chk($sformatf("%s data_b@%0d", name, i), 32'(data_b),
          to_bcd(exp_count(exp_n[i], 2, 1'b1)));
      chk($sformatf("%s data_c@%0d", name, i), 32'(data_c),
          to_bcd(exp_count(exp_n[i], 2, 1'b0)));
      chk($sformatf("%s ovf@%0d", name, i), {29'd0, ovf_a, ovf_b, ovf_c},
          {29'd0, exp_n[i] > 999999, exp_n[i] > 99, exp_n[i] > 99});
      if (exp_dv[i]) begin
        want_b += exp_couts(exp_n[i], 2, 1'b1);
        want_c += exp_couts(exp_n[i], 2, 1'b0);
        chk($sformatf("%s couts_b@%0d", name, i), 32'(seen_b), 32'(want_b));
        chk($sformatf("%s couts_c@%0d", name, i), 32'(seen_c), 32'(want_c));
      end
    end
    gq.delete();
    cq.delete();
  endtask

  initial begin
    // Directed windows: carry 9->10, spaced pulses, long window,
    // back-to-back windows, one-cycle window, empty window, overflow
    add_win(11,   0, 3);
    add_win(112,  3, 4);
    add_win(1001, 0, 4);
    add_win(121,  0, 1);
    add_win(10,   0, 4);
    add_win(1,    0, 4);
    add_win(2,    1, 4);
    add_win(151,  0, 4);
    // Randomized windows
    for (int w = 0; w < 8; w++)
      add_win($urandom_range(300, 1), 2, $urandom_range(5, 1));
    add_low(4);
    // Latch a result, then leave a 500-event window open into the next reset
    add_win(6,   0, 3);
    add_win(501, 0, 0);
    run_segment("main");

    // Reset mid-window discards it; a fresh window must still work
    add_low(5);
    add_win(4, 0, 4);
    run_segment("after_reset");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
